// File: rtl/eth_rx_frame.sv
// eth_rx_frame -- GMII receive front-end.
// Detects preamble/SFD and parses the 14-byte Ethernet header. Accepts ARP
// (0x0806) and IPv4 (0x0800) frames and forwards their payload through a
// 4-byte delay line, so the FCS never reaches the consumer. At end of frame
// it reports the CRC-32 residue check and the length/error status.
// Optional macro: ETH_RX_MAC_FILTER_EN. When it is defined, frames must be
// addressed to mac_s_addr or to broadcast. When it is undefined, the block is
// promiscuous and only the EtherType filter applies.
module eth_rx_frame (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic [7:0]  gmii_rxd,
   input  logic        gmii_rx_dv,
   input  logic        gmii_rx_er,
   input  logic [47:0] mac_s_addr,
   output logic [47:0] mac_src,
   output logic [15:0] eth_type,
   output logic        arp_rx_start,
   output logic        ip_rx_start,
   output logic [7:0]  payload_data,
   output logic        payload_valid,
   output logic        frame_done,
   output logic        fcs_ok,
   output logic        frame_err
);

   localparam logic [2:0]  ST_WAIT_IDLE = 3'd0;
   localparam logic [2:0]  ST_IDLE      = 3'd1;
   localparam logic [2:0]  ST_PREAMBLE  = 3'd2;
   localparam logic [2:0]  ST_HEADER    = 3'd3;
   localparam logic [2:0]  ST_PAYLOAD   = 3'd4;

   localparam logic [7:0]  PRE_BYTE     = 8'h55;
   localparam logic [7:0]  SFD_BYTE     = 8'hD5;
   localparam logic [15:0] TYPE_ARP     = 16'h0806;
   localparam logic [15:0] TYPE_IPV4    = 16'h0800;
   localparam logic [31:0] CRC_INIT     = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_RESIDUE  = 32'hDEBB_20E3;
   localparam logic [10:0] LEN_MAX      = 11'd1518;
   localparam logic [10:0] LEN_MIN      = 11'd64;
   localparam logic [10:0] LEN_SAT      = 11'h7FF;
   localparam logic [10:0] HDR_LAST     = 11'd13;

   // Reflected CRC-32 (0xEDB88320 is 0x04C11DB7 bit-reversed), one byte, LSB first
   function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] c;
      c = crc ^ {24'h0, data};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
      return c;
   endfunction

   logic [2:0]       state_q, state_d;
   logic [10:0]      cnt_q, cnt_d;
   logic [31:0]      crc_q, crc_d;
   logic [47:0]      src_shadow_q, src_shadow_d;
   logic [7:0]       type_hi_q, type_hi_d;
   logic [47:0]      mac_src_q, mac_src_d;
   logic [15:0]      eth_type_q, eth_type_d;
   logic             arp_start_q, arp_start_d;
   logic             ip_start_q, ip_start_d;
   logic [7:0]       pay_data_q, pay_data_d;
   logic             pay_valid_q, pay_valid_d;
   logic             done_q, done_d;
   logic             fcs_ok_q, fcs_ok_d;
   logic             err_q, err_d;
   logic             err_acc_q, err_acc_d;

   logic [3:0][7:0]  dly_data_q;
   logic [3:0]       dly_vld_q;
   logic             dly_shift;
   logic             dly_clear;

   logic [10:0]      cnt_inc;
   logic [31:0]      crc_upd;
   logic [15:0]      hdr_type;
   logic             is_arp;
   logic             is_ip;
   logic             dst_ok;

   assign cnt_inc  = (cnt_q == LEN_SAT) ? cnt_q : cnt_q + 11'd1;
   assign crc_upd  = crc32_byte(crc_q, gmii_rxd);
   assign hdr_type = {type_hi_q, gmii_rxd};
   assign is_arp   = (hdr_type == TYPE_ARP);
   assign is_ip    = (hdr_type == TYPE_IPV4);

`ifdef ETH_RX_MAC_FILTER_EN
   logic [47:0] dst_q;

   // Shift in the destination MAC (header bytes 0-5, MSB first)
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         dst_q <= '0;
      end else if (state_q == ST_HEADER && gmii_rx_dv && !gmii_rx_er && cnt_q < 11'd6) begin
         dst_q <= {dst_q[39:0], gmii_rxd};
      end
   end

   assign dst_ok = (dst_q == mac_s_addr) || (dst_q == 48'hFFFF_FFFF_FFFF);
`else
   logic unused_mac_addr;

   assign dst_ok          = 1'b1;
   assign unused_mac_addr = ^mac_s_addr;
`endif

   // Next-state logic: frame FSM, header capture, CRC, length and status
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      crc_d        = crc_q;
      src_shadow_d = src_shadow_q;
      type_hi_d    = type_hi_q;
      mac_src_d    = mac_src_q;
      eth_type_d   = eth_type_q;
      arp_start_d  = 1'b0;
      ip_start_d   = 1'b0;
      pay_data_d   = pay_data_q;
      pay_valid_d  = 1'b0;
      done_d       = 1'b0;
      fcs_ok_d     = 1'b0;
      err_d        = 1'b0;
      err_acc_d    = err_acc_q;
      dly_shift    = 1'b0;
      dly_clear    = 1'b0;

      case (state_q)
         ST_WAIT_IDLE: begin
            // Stay deaf until the line goes idle so a partial frame is never parsed
            if (!gmii_rx_dv) begin
               state_d = ST_IDLE;
            end
         end

         ST_IDLE: begin
            if (gmii_rx_dv) begin
               if (gmii_rxd == PRE_BYTE && !gmii_rx_er) begin
                  state_d = ST_PREAMBLE;
               end else begin
                  state_d = ST_WAIT_IDLE;
               end
            end
         end

         ST_PREAMBLE: begin
            if (!gmii_rx_dv) begin
               state_d = ST_IDLE;
            end else if (gmii_rx_er) begin
               state_d = ST_WAIT_IDLE;
            end else if (gmii_rxd == SFD_BYTE) begin
               state_d = ST_HEADER;
               cnt_d   = '0;
               crc_d   = CRC_INIT;
            end else if (gmii_rxd != PRE_BYTE) begin
               state_d = ST_WAIT_IDLE;
            end
         end

         ST_HEADER: begin
            if (!gmii_rx_dv) begin
               state_d = ST_IDLE;
            end else if (gmii_rx_er) begin
               state_d = ST_WAIT_IDLE;
            end else begin
               cnt_d = cnt_inc;
               crc_d = crc_upd;
               if (cnt_q >= 11'd6 && cnt_q <= 11'd11) begin
                  src_shadow_d = {src_shadow_q[39:0], gmii_rxd};
               end
               if (cnt_q == 11'd12) begin
                  type_hi_d = gmii_rxd;
               end
               if (cnt_q == HDR_LAST) begin
                  if ((is_arp || is_ip) && dst_ok) begin
                     // Commit header fields only now, so a rejected frame
                     // leaves the previous frame's values visible
                     mac_src_d   = src_shadow_q;
                     eth_type_d  = hdr_type;
                     arp_start_d = is_arp;
                     ip_start_d  = is_ip;
                     err_acc_d   = 1'b0;
                     dly_clear   = 1'b1;
                     state_d     = ST_PAYLOAD;
                  end else begin
                     state_d = ST_WAIT_IDLE;
                  end
               end
            end
         end

         ST_PAYLOAD: begin
            if (!gmii_rx_dv) begin
               // The 4 bytes still in the delay line are the FCS and are dropped
               state_d   = ST_IDLE;
               done_d    = 1'b1;
               fcs_ok_d  = (crc_q == CRC_RESIDUE);
               err_d     = err_acc_q || (cnt_q < LEN_MIN);
               dly_clear = 1'b1;
            end else begin
               cnt_d     = cnt_inc;
               crc_d     = crc_upd;
               dly_shift = 1'b1;
               if (cnt_inc > LEN_MAX) begin
                  err_acc_d = 1'b1;
               end else if (dly_vld_q[3]) begin
                  pay_valid_d = 1'b1;
                  pay_data_d  = dly_data_q[3];
               end
               if (gmii_rx_er) begin
                  err_acc_d = 1'b1;
               end
            end
         end

         default: begin
            state_d = ST_WAIT_IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q      <= ST_WAIT_IDLE;
         cnt_q        <= '0;
         crc_q        <= CRC_INIT;
         src_shadow_q <= '0;
         type_hi_q    <= '0;
         mac_src_q    <= '0;
         eth_type_q   <= '0;
         arp_start_q  <= 1'b0;
         ip_start_q   <= 1'b0;
         pay_data_q   <= '0;
         pay_valid_q  <= 1'b0;
         done_q       <= 1'b0;
         fcs_ok_q     <= 1'b0;
         err_q        <= 1'b0;
         err_acc_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         crc_q        <= crc_d;
         src_shadow_q <= src_shadow_d;
         type_hi_q    <= type_hi_d;
         mac_src_q    <= mac_src_d;
         eth_type_q   <= eth_type_d;
         arp_start_q  <= arp_start_d;
         ip_start_q   <= ip_start_d;
         pay_data_q   <= pay_data_d;
         pay_valid_q  <= pay_valid_d;
         done_q       <= done_d;
         fcs_ok_q     <= fcs_ok_d;
         err_q        <= err_d;
         err_acc_q    <= err_acc_d;
      end
   end

   // Four-stage payload delay line; stage 3 holds the oldest byte
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         dly_data_q <= '0;
         dly_vld_q  <= '0;
      end else if (dly_clear) begin
         dly_vld_q <= '0;
      end else if (dly_shift) begin
         dly_data_q <= {dly_data_q[2:0], gmii_rxd};
         dly_vld_q  <= {dly_vld_q[2:0], 1'b1};
      end
   end

   assign mac_src       = mac_src_q;
   assign eth_type      = eth_type_q;
   assign arp_rx_start  = arp_start_q;
   assign ip_rx_start   = ip_start_q;
   assign payload_data  = pay_data_q;
   assign payload_valid = pay_valid_q;
   assign frame_done    = done_q;
   assign fcs_ok        = fcs_ok_q;
   assign frame_err     = err_q;

endmodule

// File: tb/tb_eth_rx_frame.sv
// tb_eth_rx_frame -- directed scoreboard bench for eth_rx_frame.
// Expected start pulses, payload bytes and end-of-frame status are queued
// with their expected cycle as bytes are driven. A monitor pops and compares
// them when the DUT produces them.
module tb_eth_rx_frame;

   logic        aclk       = 1'b0;
   logic        aresetn    = 1'b0;
   logic [7:0]  gmii_rxd   = 8'h00;
   logic        gmii_rx_dv = 1'b0;
   logic        gmii_rx_er = 1'b0;
   logic [47:0] mac_s_addr = 48'h02_00_00_00_00_01;
   logic [47:0] mac_src;
   logic [15:0] eth_type;
   logic        arp_rx_start;
   logic        ip_rx_start;
   logic [7:0]  payload_data;
   logic        payload_valid;
   logic        frame_done;
   logic        fcs_ok;
   logic        frame_err;

   eth_rx_frame dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .gmii_rxd      (gmii_rxd),
      .gmii_rx_dv    (gmii_rx_dv),
      .gmii_rx_er    (gmii_rx_er),
      .mac_s_addr    (mac_s_addr),
      .mac_src       (mac_src),
      .eth_type      (eth_type),
      .arp_rx_start  (arp_rx_start),
      .ip_rx_start   (ip_rx_start),
      .payload_data  (payload_data),
      .payload_valid (payload_valid),
      .frame_done    (frame_done),
      .fcs_ok        (fcs_ok),
      .frame_err     (frame_err)
   );

   always #4 aclk = ~aclk;

   typedef logic [7:0] bq_t[$];
   typedef struct {logic [7:0] d; int cyc;} pay_t;
   typedef struct {logic [1:0] code; int cyc;} start_t;
   typedef struct {logic ok; logic err; int cyc;} done_t;

   localparam logic [1:0]  CODE_ARP = 2'b01;
   localparam logic [1:0]  CODE_IP  = 2'b10;
   localparam logic [47:0] BCAST    = 48'hFFFF_FFFF_FFFF;
   localparam logic [47:0] LOCAL    = 48'h02_00_00_00_00_01;
   localparam logic [47:0] OTHER    = 48'h02_00_00_00_00_99;
   localparam logic [47:0] SRC_A    = 48'h00_11_22_33_44_55;
   localparam logic [47:0] SRC_B    = 48'hA0_B1_C2_D3_E4_F5;
   localparam logic [47:0] SRC_C    = 48'h06_07_08_09_0A_0B;

   pay_t   pay_q[$];
   start_t start_q[$];
   done_t  done_q[$];

   int cyc      = 0;
   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   function automatic void chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endfunction

   // Ethernet FCS, computed bit-serially, LSB of each byte first
   function automatic logic [31:0] fcs_of(input bq_t b);
      logic [31:0] r;
      logic        fb;
      r = 32'hFFFF_FFFF;
      foreach (b[i]) begin
         for (int j = 0; j < 8; j++) begin
            fb = r[0] ^ b[i][j];
            r  = r >> 1;
            if (fb) r = r ^ 32'hEDB8_8320;
         end
      end
      return ~r;
   endfunction

   function automatic bq_t build(input logic [47:0] dst, input logic [47:0] src,
                                 input logic [15:0] et, input int len, input bit corrupt);
      bq_t         b;
      logic [31:0] fcs;
      for (int i = 0; i < 6; i++) b.push_back(dst[47-8*i -: 8]);
      for (int i = 0; i < 6; i++) b.push_back(src[47-8*i -: 8]);
      b.push_back(et[15:8]);
      b.push_back(et[7:0]);
      for (int i = 14; i < len - 4; i++) b.push_back(8'($urandom_range(0, 255)));
      fcs = fcs_of(b);
      for (int i = 0; i < 4; i++) b.push_back(fcs[8*i +: 8]);
      if (corrupt) b[len-2] = b[len-2] ^ 8'h10;
      return b;
   endfunction

   always @(posedge aclk) cyc <= cyc + 1;

   // Monitor: compare every DUT event against the head of its queue
   always @(posedge aclk) begin : mon
      pay_t   pe;
      start_t se;
      done_t  de;
      #1;
      if (payload_valid) begin
         if (pay_q.size() == 0) begin
            chk("unexpected_payload", {56'h0, payload_data}, 64'h1FF);
         end else begin
            pe = pay_q.pop_front();
            $display("cyc %0d payload 0x%02h", cyc, payload_data);
            chk("payload_data", {56'h0, payload_data}, {56'h0, pe.d});
            chk("payload_cycle", 64'(cyc), 64'(pe.cyc));
         end
      end
      if (arp_rx_start || ip_rx_start) begin
         if (start_q.size() == 0) begin
            chk("unexpected_start", {62'h0, ip_rx_start, arp_rx_start}, 64'h0);
         end else begin
            se = start_q.pop_front();
            $display("cyc %0d start ip=%0b arp=%0b", cyc, ip_rx_start, arp_rx_start);
            chk("start_code", {62'h0, ip_rx_start, arp_rx_start}, {62'h0, se.code});
            chk("start_cycle", 64'(cyc), 64'(se.cyc));
         end
      end
      if (frame_done) begin
         if (done_q.size() == 0) begin
            chk("unexpected_done", 64'h1, 64'h0);
         end else begin
            de = done_q.pop_front();
            $display("cyc %0d frame_done fcs_ok=%0b frame_err=%0b", cyc, fcs_ok, frame_err);
            chk("done_fcs_ok", {63'h0, fcs_ok}, {63'h0, de.ok});
            chk("done_frame_err", {63'h0, frame_err}, {63'h0, de.err});
            chk("done_cycle", 64'(cyc), 64'(de.cyc));
         end
      end
   end

   // Drive preamble, SFD and frame, queueing the expected DUT responses.
   // er_at: frame index carrying gmii_rx_er. rst_at: frame index where reset
   // is asserted (released 5 bytes later with dv still high).
   task automatic send_frame(input bq_t fr, input bit accept, input logic [1:0] code,
                             input bit fcs_good, input int er_at, input int rst_at);
      int n;
      int e;
      bit live;
      bit exp_err;
      n       = fr.size();
      live    = 1'b1;
      exp_err = (n < 64) || (n > 1518) || (er_at >= 0);
      for (int i = 0; i < 8; i++) begin
         @(negedge aclk);
         gmii_rx_dv = 1'b1;
         gmii_rx_er = 1'b0;
         gmii_rxd   = (i == 7) ? 8'hD5 : 8'h55;
      end
      for (int k = 0; k < n; k++) begin
         @(negedge aclk);
         if (k == rst_at) begin
            aresetn = 1'b0;
            live    = 1'b0;
            #1;
            chk("midrst_payload_valid", {63'h0, payload_valid}, 64'h0);
            chk("midrst_payload_data", {56'h0, payload_data}, 64'h0);
            chk("midrst_mac_src", {16'h0, mac_src}, 64'h0);
            chk("midrst_eth_type", {48'h0, eth_type}, 64'h0);
            chk("midrst_pending", 64'(pay_q.size() + start_q.size() + done_q.size()), 64'h0);
         end
         if (rst_at >= 0 && k == rst_at + 5) aresetn = 1'b1;
         gmii_rxd   = fr[k];
         gmii_rx_er = (k == er_at);
         e = cyc + 1;
         if (live && accept) begin
            if (k == 13) start_q.push_back('{code: code, cyc: e});
            if (k >= 18 && k + 1 <= 1518) pay_q.push_back('{d: fr[k-4], cyc: e});
         end
      end
      @(negedge aclk);
      gmii_rx_dv = 1'b0;
      gmii_rx_er = 1'b0;
      gmii_rxd   = 8'h00;
      e = cyc + 1;
      if (live && accept) done_q.push_back('{ok: fcs_good, err: exp_err, cyc: e});
   endtask

   task automatic drain(input string tag);
      repeat (8) @(negedge aclk);
      chk({tag, "_pay_left"}, 64'(pay_q.size()), 64'h0);
      chk({tag, "_start_left"}, 64'(start_q.size()), 64'h0);
      chk({tag, "_done_left"}, 64'(done_q.size()), 64'h0);
      pay_q.delete();
      start_q.delete();
      done_q.delete();
   endtask

   initial begin : stim
      bq_t fr;
      bit  filt_accept;
`ifdef ETH_RX_MAC_FILTER_EN
      filt_accept = 1'b0;
`else
      filt_accept = 1'b1;
`endif
      // Reset values
      repeat (3) @(negedge aclk);
      #1;
      chk("rst_mac_src", {16'h0, mac_src}, 64'h0);
      chk("rst_eth_type", {48'h0, eth_type}, 64'h0);
      chk("rst_arp_start", {63'h0, arp_rx_start}, 64'h0);
      chk("rst_ip_start", {63'h0, ip_rx_start}, 64'h0);
      chk("rst_payload_data", {56'h0, payload_data}, 64'h0);
      chk("rst_payload_valid", {63'h0, payload_valid}, 64'h0);
      chk("rst_frame_done", {63'h0, frame_done}, 64'h0);
      chk("rst_fcs_ok", {63'h0, fcs_ok}, 64'h0);
      chk("rst_frame_err", {63'h0, frame_err}, 64'h0);
      aresetn = 1'b1;
      repeat (3) @(negedge aclk);

      // ARP broadcast, 60 bytes + FCS
      fr = build(BCAST, SRC_A, 16'h0806, 64, 1'b0);
      send_frame(fr, 1'b1, CODE_ARP, 1'b1, -1, -1);
      drain("arp");
      chk("arp_mac_src", {16'h0, mac_src}, {16'h0, SRC_A});
      chk("arp_eth_type", {48'h0, eth_type}, 64'h0806);

      // IPv4 with one FCS bit flipped
      fr = build(LOCAL, SRC_B, 16'h0800, 80, 1'b1);
      send_frame(fr, 1'b1, CODE_IP, 1'b0, -1, -1);
      drain("badfcs");
      chk("badfcs_mac_src", {16'h0, mac_src}, {16'h0, SRC_B});
      chk("badfcs_eth_type", {48'h0, eth_type}, 64'h0800);

      // Back-to-back IPv4 frames with a one-cycle gap
      fr = build(LOCAL, SRC_A, 16'h0800, 72, 1'b0);
      send_frame(fr, 1'b1, CODE_IP, 1'b1, -1, -1);
      fr = build(BCAST, SRC_C, 16'h0806, 64, 1'b0);
      send_frame(fr, 1'b1, CODE_ARP, 1'b1, -1, -1);
      drain("b2b");
      chk("b2b_mac_src", {16'h0, mac_src}, {16'h0, SRC_C});

      // Destination not local and not broadcast
      fr = build(OTHER, SRC_B, 16'h0800, 70, 1'b0);
      send_frame(fr, filt_accept, CODE_IP, 1'b1, -1, -1);
      drain("filter");
      chk("filter_mac_src", {16'h0, mac_src}, filt_accept ? {16'h0, SRC_B} : {16'h0, SRC_C});

      // Unsupported EtherType is dropped; previous header fields hold
      fr = build(BCAST, SRC_A, 16'h86DD, 80, 1'b0);
      send_frame(fr, 1'b0, CODE_IP, 1'b1, -1, -1);
      drain("ipv6");
      chk("ipv6_mac_src_hold", {16'h0, mac_src}, filt_accept ? {16'h0, SRC_B} : {16'h0, SRC_C});

      // 50-byte runt
      fr = build(LOCAL, SRC_A, 16'h0800, 50, 1'b0);
      send_frame(fr, 1'b1, CODE_IP, 1'b1, -1, -1);
      drain("runt");

      // gmii_rx_er on payload byte 20
      fr = build(LOCAL, SRC_B, 16'h0800, 100, 1'b0);
      send_frame(fr, 1'b1, CODE_IP, 1'b1, 14 + 20, -1);
      drain("rxer");

      // 1600-byte oversize frame
      fr = build(LOCAL, SRC_C, 16'h0800, 1600, 1'b0);
      send_frame(fr, 1'b1, CODE_IP, 1'b1, -1, -1);
      drain("oversize");

      // Reset mid-payload, released with dv high, then a frame after a one-cycle gap
      fr = build(LOCAL, SRC_A, 16'h0800, 100, 1'b0);
      send_frame(fr, 1'b1, CODE_IP, 1'b1, -1, 40);
      fr = build(BCAST, SRC_B, 16'h0806, 64, 1'b0);
      send_frame(fr, 1'b1, CODE_ARP, 1'b1, -1, -1);
      drain("postrst");
      chk("postrst_mac_src", {16'h0, mac_src}, {16'h0, SRC_B});
      chk("postrst_eth_type", {48'h0, eth_type}, 64'h0806);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/eth_rx_frame.md
# eth_rx_frame

GMII receive front-end for the Ethernet stack: the receive counterpart of the transmit path. It runs in the GMII receive clock domain and detects preamble/SFD, parses the 14-byte Ethernet header, and filters frames on destination MAC and EtherType (ARP 0x0806, IPv4 0x0800). It forwards payload bytes with the 4 FCS bytes stripped and reports FCS and length status at end of frame, for consumption by the downstream ARP/IP/UDP/ICMP receive parsers.

## Interface
- No parameters.
- `aclk`  in  1  GMII receive clock, 125 MHz.
- `aresetn`  in  1  reset; one clock; asynchronous, active-low.
- `gmii_rxd`  in  8  receive data.
- `gmii_rx_dv`  in  1  receive data valid.
- `gmii_rx_er`  in  1  receive error.
- `mac_s_addr`  in  48  local MAC address, quasi-static.
- `mac_src`  out  48  peer source MAC of last accepted frame.
- `eth_type`  out  16  EtherType of last accepted frame.
- `arp_rx_start`  out  1  one-cycle pulse: ARP frame accepted.
- `ip_rx_start`  out  1  one-cycle pulse: IPv4 frame accepted.
- `payload_data`  out  8  payload byte.
- `payload_valid`  out  1  `payload_data` qualifier.
- `frame_done`  out  1  one-cycle end-of-frame pulse.
- `fcs_ok`  out  1  FCS check result; meaningful only while `frame_done` is high.
- `frame_err`  out  1  error flag; meaningful only while `frame_done` is high.

## Operation
- **States:** WAIT_IDLE, IDLE, PREAMBLE, HEADER, PAYLOAD.
- **WAIT_IDLE** is the reset state. It moves to IDLE on the first edge that samples `gmii_rx_dv`=0, so a frame already in progress at reset release is never parsed.
- **IDLE:**
  - `dv`=1 and `rxd`=0x55 and not `er`: go to PREAMBLE.
  - `dv`=1 otherwise: go to WAIT_IDLE.
- **PREAMBLE:**
  - `rxd`=0x55: stay.
  - `rxd`=0xD5: go to HEADER, clear byte counter and CRC register to 0xFFFFFFFF.
  - Any other byte, `er`=1, or `dv`=0: go to WAIT_IDLE (or to IDLE if `dv`=0).
- **HEADER:** 14 bytes, counter 0..13.
  - Bytes 0-5 are the destination MAC, bytes 6-11 are shadow-captured as `mac_src`, bytes 12-13 are `eth_type`, MSB first.
  - At byte 13 the frame is accepted only if EtherType is 0x0806 or 0x0800 and the destination MAC check passes (see Configuration).
  - Accept: commit `mac_src` and `eth_type`, pulse `arp_rx_start` or `ip_rx_start` the next cycle, go to PAYLOAD.
  - Reject: go to WAIT_IDLE with no `frame_done`.
  - `dv`=0 or `er`=1 in HEADER: go to WAIT_IDLE (or IDLE if `dv`=0), no `frame_done`.
- **CRC:**
  - Reflected CRC-32 (poly 0x04C11DB7), byte-wide, over every byte from destination MAC through FCS.
  - Residue check: `fcs_ok`=1 iff the register equals 0xDEBB20E3 after the last byte.
- **Payload delay line:** in PAYLOAD each byte enters a 4-stage shift. A byte leaves to `payload_data` with `payload_valid`=1 only when a further byte is shifted in behind it. When `dv` falls, the 4 FCS bytes remaining in the line are discarded.
- **Length:** an 11-bit frame byte counter (destination MAC through FCS) saturates at 2047.
  - Count > 1518: suppress `payload_valid`, latch `frame_err`, remain in PAYLOAD.
  - At end, count < 64: `frame_err`=1 (runt).
  - `gmii_rx_er`=1 in PAYLOAD latches `frame_err`.
- **End of frame:** the first edge in PAYLOAD sampling `dv`=0 returns to IDLE, and `frame_done` is asserted together with `fcs_ok` and `frame_err`. Every frame that enters PAYLOAD produces exactly one `frame_done`.

## Timing
- **Reset values:**
  - `mac_src`=0, `eth_type`=0.
  - All pulses/valids=0; `payload_data`=0; `fcs_ok`=0; `frame_err`=0.
  - Asynchronous reset mid-frame clears the delay line and all flags immediately.
- **Accept pulse:** `arp_rx_start`/`ip_rx_start` is high in the cycle after the edge sampling header byte 13.
- **Payload latency:** a payload byte sampled at edge n is output from edge n+4 (registered, 4-cycle latency). Bursts are contiguous at one byte per clock.
- **End-of-frame:** `frame_done` is high in the cycle after the edge that first samples `dv`=0. There is no `payload_valid` in that cycle or after.
- **Back-to-back frames:**
  - Minimum inter-frame gap is 1 cycle of `dv`=0.
  - The `frame_done` cycle is IDLE, so a 0x55 sampled there starts a new preamble.
  - `mac_src` and `eth_type` of the old frame hold until the new frame is accepted.
- **No backpressure:** the consumer must accept every `payload_valid` byte.

## Configuration
- `ETH_RX_MAC_FILTER_EN` defined: the destination MAC must equal `mac_s_addr` or FF:FF:FF:FF:FF:FF, otherwise the frame is rejected in HEADER.
- Macro undefined: promiscuous mode; every destination MAC passes and only the EtherType filter applies.

## Test plan
- **ARP broadcast:** 7×0x55, 0xD5, 60-byte ARP request to FF:FF:FF:FF:FF:FF plus correct FCS -> `arp_rx_start` pulse, 46 payload bytes matching input, `frame_done`=1, `fcs_ok`=1, `frame_err`=0.
- **Corrupted FCS:** same IPv4/UDP frame with one FCS bit flipped -> `ip_rx_start` pulse, `frame_done` with `fcs_ok`=0.
- **Filter:** destination 02:00:00:00:00:99 while `mac_s_addr`=02:00:00:00:00:01 -> with `ETH_RX_MAC_FILTER_EN`: no start pulse, no payload, no `frame_done`; without it: frame accepted.
- **Error cases:** EtherType 0x86DD -> dropped silently. 50-byte runt -> `frame_done` with `frame_err`=1. `gmii_rx_er` pulse at payload byte 20 -> `frame_err`=1.
- **Oversize:** 1600-byte frame -> payload stops after frame byte 1518, `frame_err`=1 at `frame_done`.
- **Reset and gap:** `aresetn` asserted mid-payload, released while `dv`=1 -> no output until `dv` falls. Next frame with 1-cycle gap -> parsed normally.
